// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory bus arbiter family.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    RELEASE
  } arb_state_t;

  localparam logic [31:0] BERR_RDATA = 32'h0;

  localparam int M0 = 0;
  localparam int M1 = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the master that did not
// win last time is granted.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == 1'(M1)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the shared data-memory bus with a
// bus-timeout error path. Every output comes straight from a flop.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_as_l,
  input  logic              m0_we_l,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_dtack,
  output logic              m0_berr,
  input  logic              m1_as_l,
  input  logic              m1_we_l,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_dtack,
  output logic              m1_berr,
  output logic              s_as_l,
  output logic              s_we_l,
  output logic [3:0]        s_be,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_dtack,
  output logic [1:0]        owner
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_t state, state_n;
  logic                   last_grant, last_grant_n;
  logic [TW-1:0]          timer, timer_n;
  logic [1:0]             owner_n;
  logic                   s_as_l_n, s_we_l_n;
  logic [3:0]             s_be_n;
  logic [ADDR_W-1:0]      s_addr_n;
  logic [DATA_W-1:0]      s_wdata_n;
  logic [1:0]             dtack_q, dtack_n;
  logic [1:0]             berr_q, berr_n;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_n;

  logic [1:0] req, grant;
  logic       own_idx, own_as_l, win;

  assign req      = {~m1_as_l, ~m0_as_l};
  assign own_idx  = owner[1];
  assign own_as_l = own_idx ? m1_as_l : m0_as_l;
  assign win      = grant[1];

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign m0_rdata = rdata_q[M0];
  assign m1_rdata = rdata_q[M1];
  assign m0_dtack = dtack_q[M0];
  assign m1_dtack = dtack_q[M1];
  assign m0_berr  = berr_q[M0];
  assign m1_berr  = berr_q[M1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'(M1);
      timer      <= '0;
      owner      <= 2'b00;
      s_as_l     <= 1'b1;
      s_we_l     <= 1'b1;
      s_be       <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      dtack_q    <= '0;
      berr_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      timer      <= timer_n;
      owner      <= owner_n;
      s_as_l     <= s_as_l_n;
      s_we_l     <= s_we_l_n;
      s_be       <= s_be_n;
      s_addr     <= s_addr_n;
      s_wdata    <= s_wdata_n;
      dtack_q    <= dtack_n;
      berr_q     <= berr_n;
      rdata_q    <= rdata_n;
    end
  end

  // Slave acknowledge beats the timeout, which beats an owner abort.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    timer_n      = timer;
    owner_n      = owner;
    s_as_l_n     = s_as_l;
    s_we_l_n     = s_we_l;
    s_be_n       = s_be;
    s_addr_n     = s_addr;
    s_wdata_n    = s_wdata;
    dtack_n      = dtack_q;
    berr_n       = berr_q;
    rdata_n      = rdata_q;

    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          s_as_l_n     = 1'b0;
          s_we_l_n     = win ? m1_we_l  : m0_we_l;
          s_be_n       = win ? m1_be    : m0_be;
          s_addr_n     = win ? m1_addr  : m0_addr;
          s_wdata_n    = win ? m1_wdata : m0_wdata;
          owner_n      = grant;
          timer_n      = '0;
          last_grant_n = win;
          state_n      = BUSY;
        end
      end
      BUSY: begin
        if (s_dtack) begin
          rdata_n[own_idx] = s_rdata;
          dtack_n[own_idx] = 1'b1;
          s_as_l_n         = 1'b1;
          s_we_l_n         = 1'b1;
          state_n          = ACK;
        end else if (timer == TIMER_LAST) begin
          rdata_n[own_idx] = DATA_W'(BERR_RDATA);
          dtack_n[own_idx] = 1'b1;
          berr_n[own_idx]  = 1'b1;
          s_as_l_n         = 1'b1;
          s_we_l_n         = 1'b1;
          state_n          = ACK;
        end else if (own_as_l) begin
          s_as_l_n = 1'b1;
          owner_n  = 2'b00;
          state_n  = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ACK: begin
        if (own_as_l) begin
          dtack_n = '0;
          berr_n  = '0;
          owner_n = 2'b00;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared data-memory bus.
- Master 0 is the CPU core; master 1 is the DMA/debug loader.
- Each master sees the same active-low AS_L/WE_L strobe, byte-enable and DTAck protocol as a direct slave connection.
- Sits between the masters and the memory/peripheral decode; adds a bus-timeout error path.

Parameters:
ADDR_W, 10, address width of masters and slave
DATA_W, 32, data bus width
TIMEOUT, 255, max cycles in BUSY waiting for s_dtack before bus error (1..65535)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
m0_as_l  input  1  master 0 address strobe, active-low; low = request
m0_we_l  input  1  master 0 write enable, active-low
m0_be  input  4  master 0 byte enables
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_rdata  output  DATA_W  master 0 read data
m0_dtack  output  1  master 0 transfer acknowledge, active-high
m0_berr  output  1  master 0 bus error (timeout), valid with m0_dtack
m1_as_l, m1_we_l, m1_be, m1_addr, m1_wdata, m1_rdata, m1_dtack, m1_berr: as m0, for master 1
s_as_l  output  1  slave address strobe, active-low
s_we_l  output  1  slave write enable, active-low
s_be  output  4  slave byte enables
s_addr  output  ADDR_W  slave address
s_wdata  output  DATA_W  slave write data
s_rdata  input  DATA_W  slave read data
s_dtack  input  1  slave acknowledge, active-high
owner  output  2  one-hot current grant (01 = m0, 10 = m1, 00 = none)

Behaviour:
- All outputs registered. Reset values:
  - s_as_l = 1, s_we_l = 1
  - s_be, s_addr, s_wdata = 0
  - m*_dtack = 0, m*_berr = 0, m*_rdata = 0
  - owner = 00, state = IDLE, last_grant = m1, timer = 0
- FSM states: IDLE, BUSY, ACK, RELEASE.
- IDLE:
  - If any m*_as_l is low in cycle N, grant the winner.
  - In cycle N+1: latch the winner's we_l/be/addr/wdata onto the s_* outputs, drive s_as_l = 0, set owner, clear timer, go to BUSY.
  - Arbitration is round-robin. A single requester wins. On a tie, the master not equal to last_grant wins.
  - last_grant updates at grant time. After reset, m0 wins the first tie.
- BUSY:
  - timer increments each cycle; s_* outputs are held stable.
  - If s_dtack = 1: capture s_rdata into owner's m_rdata (on writes too), drive s_as_l = 1 and s_we_l = 1, assert owner's m_dtack, go to ACK.
  - Else if timer == TIMEOUT-1: drive s_as_l = 1 and s_we_l = 1, owner's m_rdata = 0, assert owner's m_dtack and m_berr, go to ACK.
  - Else if owner's as_l = 1 (abort): drive s_as_l = 1, owner = 00, go to IDLE with no dtack. A late s_dtack is ignored.
- ACK:
  - Owner's m_dtack (and m_berr if set) held high; m_rdata held.
  - When owner's as_l = 1: deassert m_dtack and m_berr, go to RELEASE.
- RELEASE: one dead cycle with owner = 00, then go to IDLE. This guarantees a minimum 1-cycle s_as_l high gap between transactions.
- m_rdata for a master holds its last value until that master's next completed transfer.
- The non-owner master's dtack and berr stay 0. Its pending request waits, with no timeout, until IDLE.
- Latency, request to m_dtack:
  - with zero-wait slave (s_dtack in first BUSY cycle): 2 cycles
  - general case: 2 + slave wait cycles
- Back-to-back alternation: with both masters requesting continuously, grants alternate m0, m1, m0, ...
- Reset mid-operation (any state): immediately returns all outputs to reset values next edge; in-flight transfer is dropped.
- Timer is TIMEOUT-sized: width = $clog2(TIMEOUT+1).

Decomposition:
- Package mem_bus_pkg:
  - state enum arb_state_t {IDLE, BUSY, ACK, RELEASE}
  - BERR_RDATA constant (32'h0)
  - master index constants M0 = 0, M1 = 1
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from (req[1:0], last_grant) → grant one-hot. Reused later for more masters.

Test Plan:
- Single m0 read, addr 10'h040, slave acks in first BUSY cycle with 32'hCAFEF00D → s_as_l low cycle N+1, m0_dtack high cycle N+2, m0_rdata = 32'hCAFEF00D, owner = 01.
- m0 and m1 request same cycle after reset → m0 granted first. After m0 releases, m1 is granted following RELEASE, with s_addr = m1_addr.
- m1 write, be = 4'b0011, wdata 32'h1234ABCD, slave waits 5 cycles → s_we_l = 0 and s_wdata stable for all 5 cycles; m1_dtack 7 cycles after request; m0_dtack stays 0.
- Slave never acks, TIMEOUT = 8 → s_as_l high after 8 BUSY cycles, m0_dtack = m0_berr = 1, m0_rdata = 0. Both clear when m0_as_l rises.
- m0 aborts (as_l high) in 2nd BUSY cycle, slave acks next cycle → no m0_dtack, owner = 00, IDLE next cycle.
- rst_n low during BUSY with m1 owner → next edge s_as_l = 1, owner = 00, m1_dtack = 0, last_grant = m1.
